branch_history_table: RTL and testbench

Direct-mapped branch history table with branch target storage. Fetch stage reads it combinationally to predict each PC and obtain the 2-bit counter state that travels down the pipeline. Stage 3 returns that same state with the resolved outcome, and the table writes the updated counter back. This block is the producer and final consumer of the `bht_state` / `is_branch` pair that the pipeline registers carry.

---
 rtl/branch_history_table.sv | 97 +++++++++
 tb/tb_branch_history_table.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// Direct-mapped branch history table with target storage and 2-bit saturating counters.
// Optional BHT_STATS_EN adds wrapping 32-bit update/allocation/mispredict counters.
module branch_history_table #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [1:0]  bht_state_out,
  input  logic        upd_en,
  input  logic        upd_is_branch,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_bht_state
`ifdef BHT_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_allocs,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  function automatic logic [1:0] sat_cnt(input logic [1:0] s, input logic taken);
    if (taken) return (s == 2'b11) ? 2'b11 : s + 2'd1;
    else       return (s == 2'b00) ? 2'b00 : s - 2'd1;
  endfunction

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];
  logic [1:0]         r_cnt [ENTRIES];

  logic [IDX_W-1:0] w_fidx, w_uidx;
  logic [TAG_W-1:0] w_ftag, w_utag;
  logic             w_fhit, w_uhit, w_fire, w_alloc;
  logic             w_unused;

  assign w_fidx   = fetch_pc[IDX_W+1:2];
  assign w_ftag   = fetch_pc[31:IDX_W+2];
  assign w_uidx   = upd_pc[IDX_W+1:2];
  assign w_utag   = upd_pc[31:IDX_W+2];
  assign w_unused = &{1'b0, fetch_pc[1:0], upd_pc[1:0]};

  // Lookup: combinational, sees pre-update contents (no bypass)
  assign w_fhit        = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign pred_hit      = w_fhit;
  assign bht_state_out = w_fhit ? r_cnt[w_fidx] : 2'b01;
  assign pred_taken    = w_fhit & bht_state_out[1];
  assign pred_target   = w_fhit ? r_tgt[w_fidx] : fetch_pc + 32'd4;

  assign w_fire  = upd_en & upd_is_branch;
  assign w_uhit  = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_alloc = w_fire & ~w_uhit & upd_taken;

  // Valid bits clear asynchronously; this also drops any update at an edge under reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_valid <= '0;
    else if (w_alloc) r_valid[w_uidx] <= 1'b1;
  end

  // Payload arrays are unreset; a write during reset lands in an invalid entry
  always_ff @(posedge clk) begin
    if (w_fire) begin
      if (w_uhit) begin
        r_cnt[w_uidx] <= sat_cnt(upd_bht_state, upd_taken);
        if (upd_taken) r_tgt[w_uidx] <= upd_target;
      end else if (upd_taken) begin
        r_tag[w_uidx] <= w_utag;
        r_tgt[w_uidx] <= upd_target;
        r_cnt[w_uidx] <= 2'b10;
      end
    end
  end

`ifdef BHT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates     <= '0;
      stat_allocs      <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (w_fire)  stat_updates <= stat_updates + 32'd1;
      if (w_alloc) stat_allocs  <= stat_allocs + 32'd1;
      if (w_fire && (upd_taken != upd_bht_state[1]))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboarded random + directed bench for branch_history_table against an array-based model.
module tb_branch_history_table;
  localparam int ENTRIES = 64;
  localparam int IDX_W = $clog2(ENTRIES);

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  bht_state_out;
  logic        upd_en = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic [1:0]  upd_bht_state = '0;
`ifdef BHT_STATS_EN
  logic [31:0] stat_updates, stat_allocs, stat_mispredicts;
`endif

  branch_history_table #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .bht_state_out(bht_state_out),
    .upd_en(upd_en), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_bht_state(upd_bht_state)
`ifdef BHT_STATS_EN
    , .stat_updates(stat_updates), .stat_allocs(stat_allocs),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          hit;
    bit          tk;
    logic [31:0] tgt;
    logic [1:0]  st;
    logic [31:0] su, sa, sm;
  } exp_t;

  exp_t q[$];
  int n_checks = 0, n_fail = 0;

  // Reference model: plain arrays indexed by (pc/4) mod ENTRIES
  bit          m_v   [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];
  logic [31:0] m_su = 0, m_sa = 0, m_sm = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic int m_state(logic [31:0] pc);
    return m_hit(pc) ? m_cnt[idx_of(pc)] : 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
    m_su = 0; m_sa = 0; m_sm = 0;
  endtask

  task automatic model_update(logic [31:0] pc, bit tk, logic [31:0] tgt, int st);
    int i;
    i = idx_of(pc);
    m_su = m_su + 1;
    if (tk != (st >= 2)) m_sm = m_sm + 1;
    if (m_hit(pc)) begin
      m_cnt[i] = tk ? ((st + 1 > 3) ? 3 : st + 1) : ((st - 1 < 0) ? 0 : st - 1);
      if (tk) m_tgt[i] = tgt;
    end else if (tk) begin
      m_v[i] = 1'b1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_cnt[i] = 2;
      m_sa = m_sa + 1;
    end
  endtask

  // mode: 0 normal, 1 reset held across the next edge, 2 reset pulse between edges
  task automatic step(input logic [31:0] fpc, input bit en, input bit isb,
                      input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                      input logic [1:0] st, input int mode);
    exp_t e;
    fetch_pc = fpc; upd_en = en; upd_is_branch = isb; upd_pc = upc;
    upd_taken = tk; upd_target = tgt; upd_bht_state = st;
    if (mode == 1) begin
      rst = 1'b1; model_reset();
    end else if (mode == 2) begin
      rst = 1'b1; model_reset(); #2; rst = 1'b0;
    end else rst = 1'b0;
    e.hit = m_hit(fpc);
    e.st  = 2'(m_state(fpc));
    e.tk  = e.hit && (m_state(fpc) >= 2);
    e.tgt = e.hit ? m_tgt[idx_of(fpc)] : fpc + 32'd4;
    e.su = m_su; e.sa = m_sa; e.sm = m_sm;
    q.push_back(e);
    if (mode != 1 && en && isb) model_update(upc, tk, tgt, int'(st));
    @(posedge clk); #1;
  endtask

  task automatic fetch_only(input logic [31:0] fpc);
    step(fpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s pc=%h actual=%h required=%h", name, fetch_pc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pred_hit", 32'(pred_hit), 32'(e.hit));
      chk("pred_taken", 32'(pred_taken), 32'(e.tk));
      chk("pred_target", pred_target, e.tgt);
      chk("bht_state_out", 32'(bht_state_out), 32'(e.st));
`ifdef BHT_STATS_EN
      chk("stat_updates", stat_updates, e.su);
      chk("stat_allocs", stat_allocs, e.sa);
      chk("stat_mispredicts", stat_mispredicts, e.sm);
`endif
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] t, i, lo;
    t  = $urandom_range(0, 3);
    i  = $urandom_range(0, 7);
    lo = $urandom_range(0, 3);
    return (t << (IDX_W + 2)) | (i << 2) | lo;
  endfunction

  initial begin
    model_reset();
    @(posedge clk); #1;
    step(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 2'b01, 1);
    step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 0);
    fetch_only(32'hFFFF_FFFC);
    // allocate 0x100, then saturate up and down
    step(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 2'b01, 0);
    step(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h280, 2'b11, 0);
    fetch_only(32'h100);
    step(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h999, 2'b00, 0);
    fetch_only(32'h100);
    // alias at same index: not-taken leaves entry, taken replaces it
    step(32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h300, 2'b01, 0);
    fetch_only(32'h100);
    step(32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 2'b01, 0);
    fetch_only(32'h100);
    fetch_only(32'h200);
    // same-cycle fetch/update of 0x100 in state 10
    step(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 2'b01, 0);
    step(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 2'b10, 0);
    fetch_only(32'h100);
    // update with upd_en low must not write
    step(32'h104, 1'b0, 1'b1, 32'h104, 1'b1, 32'h500, 2'b01, 0);
    fetch_only(32'h104);
    step(32'h108, 1'b1, 1'b1, 32'h108, 1'b1, 32'h600, 2'b01, 0);
    step(32'h108, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 2);
    fetch_only(32'h100);
    fetch_only(32'h108);
    // update at an edge while reset held is dropped
    step(32'h10C, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h700, 2'b01, 1);
    fetch_only(32'h10C);
    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] fpc, upc;
      logic [1:0] st;
      int mode;
      fpc = ($urandom_range(0, 9) == 0) ? $urandom : rand_pc();
      upc = ($urandom_range(0, 1) == 0) ? fpc : rand_pc();
      st  = ($urandom_range(0, 3) != 0) ? 2'(m_state(upc)) : 2'($urandom_range(0, 3));
      mode = ($urandom_range(0, 299) == 0) ? 1 : (($urandom_range(0, 299) == 0) ? 2 : 0);
      step(fpc, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), upc,
           1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, st, mode);
    end
    for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0 pending", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
